// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: function codes,
// sequencer states and HI/LO read-select encodings.
package muldiv_pkg;

  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_WRITE = 2'd3
  } md_state_e;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_HI   = 2'b01;
  localparam logic [1:0] MF_LO   = 2'b10;

  function automatic logic is_md_op(input logic [5:0] f);
    return (f == FN_DIVU) || (f == FN_MULTU);
  endfunction

  function automatic logic is_mf_op(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_step_counter.sv
// Iteration counter for the RUN phase: clears, counts when enabled and
// flags the terminal count against a runtime limit.
module muldiv_step_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_last
);
  import muldiv_pkg::*;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last = (r_count == i_limit);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the shared multiply/divide datapath and HI/LO
// pair; also stalls MFHI/MFLO reads while an operation is in flight.
module muldiv_sequencer #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [5:0] funct,
  input  logic       divisor_zero,
  input  logic       abort,
  output logic       op_ready,
  output logic       busy,
  output logic       dp_load,
  output logic       dp_step,
  output logic       dp_div,
  output logic       hilo_we,
  output logic       done,
  output logic       dz,
  output logic       mf_stall,
  output logic [1:0] mf_sel
);
  import muldiv_pkg::*;

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic             r_dp_div;
  logic             r_dz_pending;
  logic [1:0]       r_mf_sel;
  logic [1:0]       w_mf_sel_nxt;
  logic             w_is_md;
  logic             w_is_mf;
  logic             w_idle;
  logic             w_accept_md;
  logic             w_accept_mf;
  logic             w_last;
  logic [CNT_W-1:0] w_limit;

  assign w_is_md = is_md_op(funct);
  assign w_is_mf = is_mf_op(funct);
  assign w_idle  = (r_state == ST_IDLE);

  // Unknown functs are always "ready" so the decoder never blocks on them.
  always_comb begin
    op_ready = 1'b1;
    if (w_is_md || w_is_mf) begin
      op_ready = w_idle;
    end
  end

  assign mf_stall    = op_valid && w_is_mf && !w_idle;
  assign w_accept_md = op_valid && op_ready && !abort && w_is_md;
  assign w_accept_mf = op_valid && op_ready && !abort && w_is_mf;

  assign w_limit = r_dp_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  muldiv_step_counter #(
    .CNT_W(CNT_W)
  ) u_step_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear ((r_state != ST_RUN) || abort),
    .i_en    (r_state == ST_RUN),
    .i_limit (w_limit),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept_md) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = abort ? ST_IDLE : (r_dz_pending ? ST_WRITE : ST_RUN);
      ST_RUN:   w_state_nxt = abort ? ST_IDLE : (w_last ? ST_WRITE : ST_RUN);
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mf_sel_nxt = MF_NONE;
    if (w_accept_mf) begin
      w_mf_sel_nxt = (funct == FN_MFHI) ? MF_HI : MF_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dp_div     <= 1'b0;
      r_dz_pending <= 1'b0;
      r_mf_sel     <= MF_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_mf_sel <= w_mf_sel_nxt;
      if (w_accept_md) begin
        r_dp_div     <= (funct == FN_DIVU);
        r_dz_pending <= divisor_zero && (funct == FN_DIVU);
      end
    end
  end

  always_comb begin
    busy    = !w_idle;
    dp_load = (r_state == ST_LOAD);
    dp_step = (r_state == ST_RUN);
    hilo_we = (r_state == ST_WRITE);
    done    = (r_state == ST_WRITE);
    dz      = (r_state == ST_WRITE) && r_dz_pending;
  end

  assign dp_div = r_dp_div;
  assign mf_sel = r_mf_sel;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a timeline model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int DIVN = 32;
  localparam int MULN = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [5:0] funct = 6'd0;
  logic       divisor_zero = 1'b0;
  logic       abort = 1'b0;
  logic       op_ready, busy, dp_load, dp_step, dp_div, hilo_we, done, dz, mf_stall;
  logic [1:0] mf_sel;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(
    .DIV_CYCLES(DIVN),
    .MUL_CYCLES(MULN),
    .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
    .divisor_zero(divisor_zero), .abort(abort), .op_ready(op_ready),
    .busy(busy), .dp_load(dp_load), .dp_step(dp_step), .dp_div(dp_div),
    .hilo_we(hilo_we), .done(done), .dz(dz), .mf_stall(mf_stall), .mf_sel(mf_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is a timeline relative to its acceptance cycle.
  int         cyc = 0;
  bit         m_known = 0;
  bit         m_active = 0;
  int         m_acc = 0;
  bit         m_div = 0;
  bit         m_dz = 0;
  logic [1:0] m_mfsel = 2'b00;

  always @(negedge clk) begin
    int  rel, n, wr;
    bit  e_load, e_step, e_write, was_active;
    rel = cyc - m_acc;
    n   = m_div ? DIVN : MULN;
    wr  = m_dz ? 2 : n + 2;
    e_load  = m_active && rel == 1;
    e_step  = m_active && !m_dz && rel >= 2 && rel <= n + 1;
    e_write = m_active && rel == wr;
    if (m_known) begin
      chk("busy", busy, m_active);
      chk("dp_load", dp_load, e_load);
      chk("dp_step", dp_step, e_step);
      chk("hilo_we", hilo_we, e_write);
      chk("done", done, e_write);
      chk("dz", dz, e_write && m_dz);
      chk("mf_sel", mf_sel, m_mfsel);
      chk("op_ready", op_ready, (is_md_op(funct) || is_mf_op(funct)) ? !m_active : 1);
      chk("mf_stall", mf_stall, op_valid && is_mf_op(funct) && m_active);
      if (m_active) chk("dp_div", dp_div, m_div);
    end
    was_active = m_active;
    if (!rst_n) begin
      m_known  = 1;
      m_active = 0;
      m_mfsel  = 2'b00;
    end else begin
      if (m_active) begin
        if (e_write || abort) m_active = 0;
      end else if (op_valid && !abort && is_md_op(funct)) begin
        m_active = 1;
        m_acc    = cyc;
        m_div    = (funct == FN_DIVU);
        m_dz     = divisor_zero && (funct == FN_DIVU);
      end
      if (op_valid && !abort && is_mf_op(funct) && !was_active)
        m_mfsel = (funct == FN_MFHI) ? 2'b01 : 2'b10;
      else
        m_mfsel = 2'b00;
    end
    cyc++;
  end

  // Directed timeline capture (cycle 0 = acceptance cycle of the first op).
  int   t_load, t_steps, t_write, t_writes, t_f2acc, t_mfsel, t_stalls, t_busy_ab;
  logic t_dz;

  task automatic idle_in();
    op_valid = 0; funct = 6'd0; divisor_zero = 0; abort = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    idle_in();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("wait_idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic trace(input logic [5:0] f, input logic dzin, input int abort_cyc,
                       input logic [5:0] f2, input int f2_from);
    bit f2_done = 0;
    bit f2_drv;
    t_load = -1; t_steps = 0; t_write = -1; t_writes = 0; t_f2acc = -1;
    t_mfsel = -1; t_stalls = 0; t_busy_ab = -1; t_dz = 0;
    for (int c = 0; c <= 45; c++) begin
      idle_in();
      f2_drv = 0;
      if (c == 0) begin
        op_valid = 1; funct = f; divisor_zero = dzin;
      end else if (f2_from > 0 && c >= f2_from && !f2_done) begin
        op_valid = 1; funct = f2; f2_drv = 1;
      end
      abort = (c == abort_cyc);
      @(negedge clk);
      if (dp_load && t_load < 0) t_load = c;
      if (dp_step) t_steps++;
      if (hilo_we) begin t_write = c; t_writes++; t_dz = dz; end
      if (mf_sel != 2'b00) t_mfsel = c;
      if (mf_stall) t_stalls++;
      if (c == abort_cyc + 1) t_busy_ab = busy;
      if (f2_drv && op_ready && !abort) begin f2_done = 1; t_f2acc = c; end
      @(posedge clk); #1;
    end
    idle_in();
  endtask

  initial begin
    // Reset held with a DIVU presented.
    rst_n = 0; op_valid = 1; funct = FN_DIVU;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ready", op_ready, 1);
      chk("rst_outs", {dp_load, dp_step, hilo_we, done, dz, mf_stall, mf_sel}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1; idle_in();
    @(posedge clk); #1;

    trace(FN_DIVU, 0, -1, FN_ADD, 0);
    chk("divu_load", t_load, 1);
    chk("divu_steps", t_steps, 32);
    chk("divu_write", t_write, 34);
    chk("divu_writes", t_writes, 1);
    chk("divu_dz", t_dz, 0);
    wait_idle();

    trace(FN_DIVU, 1, -1, FN_ADD, 0);
    chk("dz_load", t_load, 1);
    chk("dz_steps", t_steps, 0);
    chk("dz_write", t_write, 2);
    chk("dz_flag", t_dz, 1);
    wait_idle();

    trace(FN_MULTU, 0, -1, FN_MFLO, 3);
    chk("mul_steps", t_steps, 20);
    chk("mul_write", t_write, 22);
    chk("mflo_stalls", t_stalls, 20);
    chk("mflo_acc", t_f2acc, 23);
    chk("mflo_sel_cyc", t_mfsel, 24);
    wait_idle();

    trace(FN_DIVU, 0, 10, FN_ADD, 0);
    chk("abort_run_writes", t_writes, 0);
    chk("abort_run_busy", t_busy_ab, 0);
    chk("abort_run_steps", t_steps, 9);
    wait_idle();

    trace(FN_DIVU, 0, 34, FN_ADD, 0);
    chk("abort_wr_write", t_write, 34);
    chk("abort_wr_writes", t_writes, 1);
    wait_idle();

    trace(FN_DIVU, 0, -1, FN_DIVU, 1);
    chk("b2b_acc", t_f2acc, 35);
    wait_idle();

    trace(FN_DIVU, 0, -1, FN_ADD, 5);
    chk("add_acc", t_f2acc, 5);
    chk("add_steps", t_steps, 32);
    chk("add_write", t_write, 34);
    wait_idle();

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      op_valid     = ($urandom_range(0, 1) == 1);
      divisor_zero = ($urandom_range(0, 3) == 0);
      abort        = ($urandom_range(0, 29) == 0);
      rst_n        = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 5))
        0: funct = FN_DIVU;
        1: funct = FN_MULTU;
        2: funct = FN_MFHI;
        3: funct = FN_MFLO;
        4: funct = FN_ADD;
        default: funct = 6'($urandom_range(0, 63));
      endcase
      @(posedge clk); #1;
    end
    rst_n = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
